// File: rtl/sram_controller_pkg.sv
// Shared FSM encoding and SRAM geometry for the 32-bit-word to 16-bit-SRAM bridge.
package sram_controller_pkg;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int DEF_BASE_ADDR = 1024;
    localparam int SRAM_AW       = 18;
    localparam int SRAM_DW       = 16;
    localparam int WCNT_W        = 8;
endpackage

// File: rtl/sram_wait_counter.sv
// Down-counter for the post-access idle cycles: load, decrement while enabled, zero flag.
// Single-cycle load/decrement, no backpressure; holds at zero.
module sram_wait_counter
    import sram_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WCNT_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic              o_zero
);
    logic [WCNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit word access into low/high 16-bit SRAM accesses plus WAIT_CYCLES idle cycles.
// ready is low for 3+WAIT_CYCLES cycles from the request; requester must hold inputs until ready.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 ready,
    inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_OE_N
);
    localparam logic [WCNT_W-1:0] W_LOAD = (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : '0;

    state_t             r_state;
    state_t             w_next;
    logic               r_is_write;
    logic [SRAM_AW-2:0] r_idx;
    logic [31:0]        r_wdata;
    logic [31:0]        r_read_data;
    logic [SRAM_AW-2:0] w_idx;
    logic               w_req;
    logic               w_drive;
    logic               w_cnt_load;
    logic               w_wait_zero;

    assign w_req = rd_en | wr_en;
    // Word index relative to the SRAM window; byte offset bits and overflow bits are dropped.
    assign w_idx = (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);

    sram_wait_counter u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (W_LOAD),
        .i_dec      (r_state == ST_WAIT),
        .o_zero     (w_wait_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        ready      = 1'b1;
        w_cnt_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next = ST_LOW;
                    ready  = 1'b0;
                end
            end
            ST_LOW: begin
                w_next = ST_HIGH;
                ready  = 1'b0;
            end
            ST_HIGH: begin
                ready = 1'b0;
                if (WAIT_CYCLES > 0) begin
                    w_next     = ST_WAIT;
                    w_cnt_load = 1'b1;
                end else begin
                    w_next = ST_DONE;
                end
            end
            ST_WAIT: begin
                ready = 1'b0;
                if (w_wait_zero) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_write  <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_req) begin
                r_is_write <= wr_en;
                r_idx      <= w_idx;
                r_wdata    <= write_data;
            end
            if (!r_is_write && (r_state == ST_LOW)) begin
                r_read_data[15:0] <= SRAM_DQ;
            end
            if (!r_is_write && (r_state == ST_HIGH)) begin
                r_read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    assign w_drive   = r_is_write && ((r_state == ST_LOW) || (r_state == ST_HIGH));
    assign SRAM_DQ   = w_drive ? ((r_state == ST_HIGH) ? r_wdata[31:16] : r_wdata[15:0]) : 'z;
    assign SRAM_WE_N = ~w_drive;
    assign SRAM_ADDR = (r_state == ST_LOW)  ? {r_idx, 1'b0} :
                       (r_state == ST_HIGH) ? {r_idx, 1'b1} : '0;
    assign read_data = r_read_data;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: default-wait controller against a small SRAM model, plus a zero-wait read-only instance.
module tb_sram_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    wire  [31:0] read_data;
    wire         ready;
    wire  [15:0] sram_dq;
    wire  [17:0] sram_addr;
    wire         ub_n, lb_n, we_n, ce_n, oe_n;

    logic        rd0;
    logic [31:0] addr0;
    logic        wr0 = 1'b0;
    logic [31:0] wdata0 = 32'h0;
    wire  [31:0] rdata0;
    wire         ready0;
    wire  [15:0] sram_dq0;
    wire  [17:0] sram_addr0;
    wire         ub_n0, lb_n0, we_n0, ce_n0, oe_n0;

    logic [15:0] mem [0:15];
    logic        mdl_clr;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          res_cnt;
    logic [17:0] res_lo_addr, res_hi_addr;
    logic        res_we_lo, res_we_hi, res_we_any;

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
        .SRAM_ADDR(sram_addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(addr0),
        .write_data(wdata0), .read_data(rdata0), .ready(ready0), .SRAM_DQ(sram_dq0),
        .SRAM_ADDR(sram_addr0), .SRAM_UB_N(ub_n0), .SRAM_LB_N(lb_n0), .SRAM_WE_N(we_n0),
        .SRAM_CE_N(ce_n0), .SRAM_OE_N(oe_n0)
    );

    // SRAM with OE_N/CE_N low: drives the bus whenever it is not being written.
    assign sram_dq  = we_n  ? mem[sram_addr[3:0]] : 16'hzzzz;
    assign sram_dq0 = we_n0 ? (16'hC000 | sram_addr0[15:0]) : 16'hzzzz;

    always @(posedge clk) begin
        if (mdl_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0;
        end else if (!we_n) begin
            mem[sram_addr[3:0]] <= sram_dq;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called on a falling edge in IDLE; returns in the DONE cycle (or after the cycle bound).
    task automatic run_req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        wr_en = w; rd_en = r; address = a; write_data = d;
        res_cnt = 0; res_we_any = 1'b0; res_we_lo = 1'b1; res_we_hi = 1'b1;
        res_lo_addr = '0; res_hi_addr = '0;
        #1;
        while (!ready && res_cnt < 50) begin
            if (res_cnt == 1) begin res_lo_addr = sram_addr; res_we_lo = we_n; end
            if (res_cnt == 2) begin res_hi_addr = sram_addr; res_we_hi = we_n; end
            if (!we_n) res_we_any = 1'b1;
            res_cnt++;
            @(negedge clk); #1;
        end
    endtask

    // DONE lasts one cycle: with enables still held, the following IDLE cycle drops ready again.
    task automatic end_req;
        @(negedge clk); #1;
        check("done_one_cycle", 32'(ready), 32'd0);
        wr_en = 1'b0; rd_en = 1'b0;
        #1;
        check("idle_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        mdl_clr = 1'b1; rd0 = 1'b0; addr0 = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_rdata", read_data, 32'd0);
        check("tie_lows", 32'({ub_n, lb_n, ce_n, oe_n}), 32'd0);
        mdl_clr = 1'b0; rst = 1'b0;
        @(negedge clk);

        run_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        check("wr_len", res_cnt, 32'd6);
        check("wr_lo_addr", 32'(res_lo_addr), 32'd0);
        check("wr_hi_addr", 32'(res_hi_addr), 32'd1);
        check("wr_we_lo", 32'(res_we_lo), 32'd0);
        check("wr_we_hi", 32'(res_we_hi), 32'd0);
        end_req();
        check("mem0", 32'(mem[0]), 32'h0000BEEF);
        check("mem1", 32'(mem[1]), 32'h0000DEAD);

        run_req(1'b0, 1'b1, 32'd1024, 32'h0);
        check("rd_len", res_cnt, 32'd6);
        check("rd_data", read_data, 32'hDEADBEEF);
        check("rd_we_never", 32'(res_we_any), 32'd0);
        end_req();

        run_req(1'b1, 1'b0, 32'd1032, 32'h12345678);
        check("wr2_lo_addr", 32'(res_lo_addr), 32'd4);
        check("wr2_hi_addr", 32'(res_hi_addr), 32'd5);
        end_req();
        check("mem4", 32'(mem[4]), 32'h00005678);
        check("mem5", 32'(mem[5]), 32'h00001234);

        run_req(1'b0, 1'b1, 32'd1035, 32'h0);
        check("rd2_lo_addr", 32'(res_lo_addr), 32'd4);
        check("rd2_hi_addr", 32'(res_hi_addr), 32'd5);
        check("rd2_data", read_data, 32'h12345678);
        end_req();

        run_req(1'b1, 1'b1, 32'd1028, 32'hA5A55A5A);
        check("both_len", res_cnt, 32'd6);
        check("both_we_lo", 32'(res_we_lo), 32'd0);
        check("both_rdata_kept", read_data, 32'h12345678);
        end_req();
        check("mem2", 32'(mem[2]), 32'h00005A5A);
        check("mem3", 32'(mem[3]), 32'h0000A5A5);

        // Reset in the HIGH cycle of a write over cleared memory.
        @(negedge clk);
        mdl_clr = 1'b1;
        @(negedge clk);
        mdl_clr = 1'b0;
        wr_en = 1'b1; address = 32'd1024; write_data = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk); #1;
        check("pre_rst_addr", 32'(sram_addr), 32'd1);
        check("pre_rst_we_n", 32'(we_n), 32'd0);
        rst = 1'b1;
        #1;
        check("arst_we_n", 32'(we_n), 32'd1);
        check("arst_addr", 32'(sram_addr), 32'd0);
        check("arst_rdata", read_data, 32'd0);
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_mem0", 32'(mem[0]), 32'h0000F00D);
        check("arst_mem1", 32'(mem[1]), 32'h00000000);
        check("arst_ready", 32'(ready), 32'd1);

        // Zero wait cycles: back-to-back reads, next request presented during DONE.
        rd0 = 1'b1; addr0 = 32'd1024;
        for (int r = 0; r < 2; r++) begin
            res_cnt = 0;
            #1;
            while (!ready0 && res_cnt < 20) begin
                res_cnt++;
                @(negedge clk); #1;
            end
            check("w0_len", res_cnt, 32'd3);
            check("w0_rdata", rdata0, (r == 0) ? 32'hC001C000 : 32'hC007C006);
            if (r == 0) begin
                addr0 = 32'd1036;
                @(negedge clk);
            end
        end
        rd0 = 1'b0;
        @(negedge clk); #1;
        check("w0_idle_ready", 32'(ready0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
